// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers one NxN A (rows) and B (columns) and streams them diagonally skewed into a MAC array.
// Optional macro FEEDER_JOB_CNT_EN adds a 16-bit wrapping completed-job counter output job_count.
module systolic_skew_feeder #(
    parameter  int unsigned N     = 4,
    parameter  int unsigned DW    = 8,
    parameter  int unsigned FLUSH = 2,
    localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic            ld_sel,
    input  logic [IW-1:0]   ld_idx,
    input  logic [N*DW-1:0] ld_data,
    input  logic            start,
    output logic            busy,
    output logic [N*DW-1:0] d_row,
    output logic [N*DW-1:0] w_col,
    output logic            enable,
    output logic            update_ready,
    output logic            done,
    output logic            res_capture
`ifdef FEEDER_JOB_CNT_EN
    ,
    output logic [15:0]     job_count
`endif
);

    localparam int unsigned STREAM_LEN = 3 * N - 2;
    localparam int unsigned CW         = $clog2(STREAM_LEN + FLUSH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_CAPTURE,
        S_DONE
    } state_t;

    typedef logic [N-1:0][DW-1:0] lanes_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [N-1:0][N-1:0][DW-1:0]  a_q, a_nxt;   // a[row][col]
    logic [N-1:0][N-1:0][DW-1:0]  b_q, b_nxt;   // b[row][col]
    lanes_t                       ld_lanes;
    lanes_t                       d_lanes, w_lanes;
    logic                         wr_en;
    logic                         ld_ready_d, busy_d, enable_d, update_ready_d, done_d, res_capture_d;

    assign ld_lanes = ld_data;
    assign wr_en    = (state_q == S_IDLE) && ld_valid && (32'(ld_idx) < N);

    // Buffer write view; the lane decode reads it so a load on the start edge is streamed at once.
    always_comb begin : buf_write
        a_nxt = a_q;
        b_nxt = b_q;
        if (wr_en) begin
            if (!ld_sel) begin
                a_nxt[ld_idx] = ld_lanes;
            end else begin
                for (int k = 0; k < int'(N); k++) begin
                    b_nxt[k][ld_idx] = ld_lanes[k];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin : buf_reg
        if (!RSTN) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_nxt;
            b_q <= b_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin : state_reg
        if (!RSTN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the phase counter restarts at zero on every state entry.
    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (cnt_q == CW'(STREAM_LEN - 1)) begin
                    state_d = (FLUSH == 0) ? S_CAPTURE : S_FLUSH;
                    cnt_d   = '0;
                end
            end
            S_FLUSH: begin
                if (cnt_q == CW'(FLUSH - 1)) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end
            end
            S_CAPTURE: begin
                state_d = S_DONE;
                cnt_d   = '0;
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so registered outputs line up with the state they describe.
    always_comb begin : out_decode
        int t;
        t              = int'(cnt_d);
        ld_ready_d     = 1'b0;
        busy_d         = (state_d != S_IDLE);
        enable_d       = 1'b0;
        update_ready_d = 1'b0;
        done_d         = 1'b0;
        res_capture_d  = 1'b0;
        d_lanes        = '0;
        w_lanes        = '0;
        case (state_d)
            S_IDLE: begin
                ld_ready_d = 1'b1;
                enable_d   = 1'b1;
            end
            S_STREAM: begin
                enable_d       = 1'b1;
                update_ready_d = 1'b1;
                for (int i = 0; i < int'(N); i++) begin
                    if (t >= i && (t - i) < int'(N)) begin
                        d_lanes[i] = a_nxt[i][IW'(t - i)];
                        w_lanes[i] = b_nxt[IW'(t - i)][i];
                    end
                end
            end
            S_FLUSH: begin
                enable_d       = 1'b1;
                update_ready_d = 1'b1;
            end
            S_CAPTURE: begin
                update_ready_d = 1'b1;
                res_capture_d  = 1'b1;
            end
            S_DONE: begin
                enable_d = 1'b1;
                done_d   = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin : out_reg
        if (!RSTN) begin
            ld_ready     <= 1'b0;
            busy         <= 1'b0;
            enable       <= 1'b0;
            update_ready <= 1'b0;
            done         <= 1'b0;
            res_capture  <= 1'b0;
            d_row        <= '0;
            w_col        <= '0;
        end else begin
            ld_ready     <= ld_ready_d;
            busy         <= busy_d;
            enable       <= enable_d;
            update_ready <= update_ready_d;
            done         <= done_d;
            res_capture  <= res_capture_d;
            d_row        <= d_lanes;
            w_col        <= w_lanes;
        end
    end

`ifdef FEEDER_JOB_CNT_EN
    // Counts DONE cycles; wraps naturally at 16 bits.
    always_ff @(posedge CLK or negedge RSTN) begin : job_cnt_reg
        if (!RSTN) begin
            job_count <= '0;
        end else if (state_q == S_DONE) begin
            job_count <= job_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (N=4, DW=8, FLUSH=2) with an ideal systolic-array product check.
module tb_systolic_skew_feeder;

    logic        CLK;
    logic        RSTN;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_sel;
    logic [1:0]  ld_idx;
    logic [31:0] ld_data;
    logic        start;
    logic        busy;
    logic [31:0] d_row;
    logic [31:0] w_col;
    logic        enable;
    logic        update_ready;
    logic        done;
    logic        res_capture;
`ifdef FEEDER_JOB_CNT_EN
    logic [15:0] job_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] d_hist [12];
    logic [31:0] w_hist [12];

    systolic_skew_feeder dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_sel       (ld_sel),
        .ld_idx       (ld_idx),
        .ld_data      (ld_data),
        .start        (start),
        .busy         (busy),
        .d_row        (d_row),
        .w_col        (w_col),
        .enable       (enable),
        .update_ready (update_ready),
        .done         (done),
        .res_capture  (res_capture)
`ifdef FEEDER_JOB_CNT_EN
        ,
        .job_count    (job_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic sel, input logic [1:0] idx, input logic [31:0] data);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_idx   = idx;
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
        ld_data  = '0;
    endtask

    initial begin
        int acc;
        int n;
        logic [31:0] or_d;
        logic [31:0] or_w;

        RSTN     = 1'b0;
        ld_valid = 1'b0;
        ld_sel   = 1'b0;
        ld_idx   = '0;
        ld_data  = '0;
        start    = 1'b0;

        // Reset state
        #12;
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_enable",   32'(enable),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_d_row",    d_row,         32'd0);
        check("rst_w_col",    w_col,         32'd0);
        RSTN = 1'b1;
        tick();
        check("idle_ld_ready", 32'(ld_ready),     32'd1);
        check("idle_enable",   32'(enable),       32'd1);
        check("idle_upd",      32'(update_ready), 32'd0);

        // Job 1: A = identity, B[k][j] = 4k+j+1
        load(1'b0, 2'd0, 32'h00000001);
        load(1'b0, 2'd1, 32'h00000100);
        load(1'b0, 2'd2, 32'h00010000);
        load(1'b0, 2'd3, 32'h01000000);
        load(1'b1, 2'd0, 32'h0d090501);
        load(1'b1, 2'd1, 32'h0e0a0602);
        load(1'b1, 2'd2, 32'h0f0b0703);
        load(1'b1, 2'd3, 32'h100c0804);
        start = 1'b1;
        tick();
        start = 1'b0;
        d_hist[0] = d_row;
        w_hist[0] = w_col;
        check("j1_t0_d_row", d_row, 32'h00000001);
        check("j1_t0_w_col", w_col, 32'h00000001);
        check("j1_t0_busy",  32'(busy),         32'd1);
        check("j1_t0_ldrdy", 32'(ld_ready),     32'd0);
        check("j1_t0_upd",   32'(update_ready), 32'd1);
        for (int k = 1; k < 12; k++) begin
            tick();
            d_hist[k] = d_row;
            w_hist[k] = w_col;
            if (k == 3) check("j1_t3_w_col", w_col, 32'h04070a0d);
        end
        check("j1_flush_res", 32'(res_capture), 32'd0);
        check("j1_flush_en",  32'(enable),      32'd1);
        tick();
        check("j1_cap_res", 32'(res_capture),  32'd1);
        check("j1_cap_en",  32'(enable),       32'd0);
        check("j1_cap_upd", 32'(update_ready), 32'd1);
        check("j1_cap_lanes", d_row | w_col,   32'd0);
        tick();
        check("j1_done",     32'(done),         32'd1);
        check("j1_done_res", 32'(res_capture),  32'd0);
        check("j1_done_upd", 32'(update_ready), 32'd0);
        check("j1_done_en",  32'(enable),       32'd1);
        check("j1_done_busy", 32'(busy),        32'd1);
        tick();
        check("j1_end_busy",  32'(busy),     32'd0);
        check("j1_end_done",  32'(done),     32'd0);
        check("j1_end_ldrdy", 32'(ld_ready), 32'd1);
`ifdef FEEDER_JOB_CNT_EN
        check("j1_job_count", 32'(job_count), 32'd1);
`endif
        // Ideal array: PE(i,j) at time tau multiplies d_row[i](tau-j) by w_col[j](tau-i).
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int tau = 0; tau < 20; tau++) begin
                    if (tau - j >= 0 && tau - j < 12 && tau - i >= 0 && tau - i < 12)
                        acc += int'(d_hist[tau - j][i*8 +: 8]) * int'(w_hist[tau - i][j*8 +: 8]);
                end
                check($sformatf("j1_C%0d%0d", i, j), 32'(acc), 32'(4*i + j + 1));
            end
        end

        // Job 2: distinct A, skew positions, and loads/start while busy
        load(1'b0, 2'd0, 32'h04030201);
        load(1'b0, 2'd1, 32'h14131211);
        load(1'b0, 2'd2, 32'h24232221);
        load(1'b0, 2'd3, 32'h34333231);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("j2_t0_d_row", d_row, 32'h00000001);
        tick();
        tick();
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_idx   = 2'd0;
        ld_data  = 32'hFFFFFFFF;
        start    = 1'b1;
        tick();
        ld_valid = 1'b0;
        start    = 1'b0;
        ld_data  = '0;
        check("j2_t3_ldrdy", 32'(ld_ready), 32'd0);
        check("j2_t3_d_row", d_row, 32'h31221304);
        check("j2_t3_w_col", w_col, 32'h04070a0d);
        tick();
        tick();
        tick();
        check("j2_t6_d_row", d_row, 32'h34000000);
        check("j2_t6_w_col", w_col, 32'h10000000);
        tick();
        check("j2_t7_d_row", d_row, 32'h00000000);
        check("j2_t7_w_col", w_col, 32'h00000000);
        tick();
        tick();
        check("j2_t9_upd", 32'(update_ready), 32'd1);
        check("j2_t9_res", 32'(res_capture),  32'd0);
        tick();
        check("j2_flush_lanes", d_row | w_col, 32'd0);
        tick();
        tick();
        check("j2_cap_res", 32'(res_capture), 32'd1);
        tick();
        check("j2_done", 32'(done), 32'd1);
        tick();
        check("j2_end_busy", 32'(busy), 32'd0);
        tick();
        check("j2_no_requeue_busy", 32'(busy), 32'd0);
`ifdef FEEDER_JOB_CNT_EN
        check("j2_job_count", 32'(job_count), 32'd2);
`endif

        // Job 3: load and start in the same cycle
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_idx   = 2'd0;
        ld_data  = 32'hFFFFFFFF;
        start    = 1'b1;
        tick();
        ld_valid = 1'b0;
        start    = 1'b0;
        ld_data  = '0;
        check("j3_t0_d_row", d_row, 32'h000000FF);
        check("j3_t0_w_col", w_col, 32'h00000001);
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        check("j3_finish_busy", 32'(busy), 32'd0);

        // Job 4: reset at STREAM cycle 5
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        check("j4_t5_busy", 32'(busy), 32'd1);
        RSTN = 1'b0;
        #1;
        check("mid_rst_busy",  32'(busy),         32'd0);
        check("mid_rst_lanes", d_row | w_col,     32'd0);
        check("mid_rst_en",    32'(enable),       32'd0);
        check("mid_rst_upd",   32'(update_ready), 32'd0);
        #2;
        RSTN = 1'b1;
        tick();
        check("post_rst_ldrdy", 32'(ld_ready), 32'd1);

        // Job 5: buffers were cleared, so every lane streams zero
        start = 1'b1;
        tick();
        start = 1'b0;
        check("j5_t0_d_row", d_row, 32'd0);
        check("j5_t0_w_col", w_col, 32'd0);
        check("j5_t0_busy",  32'(busy), 32'd1);
        or_d = '0;
        or_w = '0;
        for (int k = 1; k < 10; k++) begin
            tick();
            or_d |= d_row;
            or_w |= w_col;
        end
        check("j5_stream_d_or", or_d, 32'd0);
        check("j5_stream_w_or", or_w, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
